store_rmw: RTL and testbench

Sub-word store engine for the MEM stage of the 5-cycle MIPS core. It accepts SW/SH/SB requests from the pipeline and turns SH/SB into a read-modify-write of the addressed word in the word-wide data RAM. The byte/halfword is merged in big-endian order: byte address offset 00 is data bits [31:24]. While busy it stalls the pipeline through its request handshake.

---
 rtl/store_rmw.sv | 144 ++++++++++++++
 tb/tb_store_rmw.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/store_rmw.sv
// Sub-word store engine: SW written directly, SH/SB via read-modify-write, big-endian lanes.
// Latency: SW 1 cycle, SH/SB 3 cycles, error 1 cycle from accept to the done pulse.
// Backpressure: req_ready is high only in IDLE, so a new request waits until the previous one finishes.
module store_rmw (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic [29:0] mem_addr,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] OP_SW  = 2'b00;
   localparam logic [1:0] OP_SH  = 2'b01;
   localparam logic [1:0] OP_SB  = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      ERR   = 3'd4
   } state_t;

   // Latched copy of the accepted request; the live req_* bus is ignored once busy.
   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   state_t      state_q;
   state_t      state_d;
   req_t        req_q;
   logic [31:0] merge_q;
   logic        accept;
   logic        bad_req;
   logic        sub_word;

   // Insert the store byte/halfword into the word read from RAM.
   // Byte offset 00 is the most significant lane (big-endian).
   function automatic logic [31:0] merge_word(input logic [1:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] data,
                                              input logic [31:0] w);
      logic [31:0] r;
      r = w;
      if (op == OP_SH) begin
         if (off[1] == 1'b0) r = {data[15:0], w[15:0]};
         else                r = {w[31:16], data[15:0]};
      end else begin
         case (off)
            2'b00:   r = {data[7:0], w[23:0]};
            2'b01:   r = {w[31:24], data[7:0], w[15:0]};
            2'b10:   r = {w[31:16], data[7:0], w[7:0]};
            default: r = {w[31:8], data[7:0]};
         endcase
      end
      return r;
   endfunction

   assign accept   = req_valid & req_ready;
   assign sub_word = (req_op == OP_SH) || (req_op == OP_SB);

   // Reject reserved op, misaligned word store and odd halfword store at accept time.
   always_comb begin
      bad_req = 1'b0;
      if (req_op == OP_RSV)                                   bad_req = 1'b1;
      else if ((req_op == OP_SW) && (req_addr[1:0] != 2'b00)) bad_req = 1'b1;
      else if ((req_op == OP_SH) && req_addr[0])              bad_req = 1'b1;
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Request latch on accept; merge register loads only in WAIT, so rdata elsewhere is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= '0;
         merge_q <= '0;
      end else begin
         if (accept) req_q <= '{op: req_op, addr: req_addr, data: req_data};
         if (state_q == WAIT)
            merge_q <= merge_word(req_q.op, req_q.addr[1:0], req_q.data, mem_rdata);
      end
   end

   // Next-state and strobe decode; all strobes come straight from the state register.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               if (bad_req)       state_d = ERR;
               else if (sub_word) state_d = READ;
               else               state_d = WRITE;
            end
         end
         READ: begin
            mem_re  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            state_d = WRITE;
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_wdata = (req_q.op == OP_SW) ? req_q.data : merge_q;
            done      = 1'b1;
            state_d   = IDLE;
         end
         ERR: begin
            done    = 1'b1;
            err     = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_addr = req_q.addr[31:2];

endmodule

// File: tb/tb_store_rmw.sv
module tb_store_rmw;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [29:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        done;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   logic [31:0] ram_word = 32'h11223344;

   store_rmw dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // RAM read port: data valid the cycle after mem_re, garbage otherwise.
   always @(posedge clk) begin
      mem_rdata <= mem_re ? ram_word : 32'h5A5A5A5A;
      if (mem_we) we_cnt <= we_cnt + 1;
      if (mem_re) re_cnt <= re_cnt + 1;
   end

   task automatic test_reset();
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0h want 1", req_ready); end
      n_cmp++; if ({mem_re, mem_we, done, err} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {mem_re, mem_we, done, err}); end
      n_cmp++; if (mem_addr !== 30'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
      n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
   endtask

   task automatic test_sw();
      int re0;
      re0 = re_cnt;
      @(negedge clk); req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h100; req_data = 32'hDEADBEEF;
      @(negedge clk);
      n_cmp++; if ({mem_we, done, err, mem_re} !== 4'b1100) begin n_fail++; $display("FAIL sw_strobes: got %b want 1100", {mem_we, done, err, mem_re}); end
      n_cmp++; if (mem_addr !== 30'h40) begin n_fail++; $display("FAIL sw_addr: got %h want 40", mem_addr); end
      n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_busy_ready: got %0h want 0", req_ready); end
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_we, done} !== 3'b100) begin n_fail++; $display("FAIL sw_after: got %b want 100", {req_ready, mem_we, done}); end
      n_cmp++; if (re_cnt !== re0) begin n_fail++; $display("FAIL sw_no_read: got %0d reads want %0d", re_cnt, re0); end
   endtask

   task automatic test_sub(input logic [1:0] op, input logic [1:0] off, input logic [31:0] data,
                           input logic [31:0] exp, input logic [29:0] exp_addr);
      @(negedge clk); req_valid = 1'b1; req_op = op; req_addr = {exp_addr, off}; req_data = data;
      @(negedge clk);
      n_cmp++; if ({mem_re, mem_we, done, req_ready} !== 4'b1000) begin n_fail++; $display("FAIL sub_read op%0d off%0d: got %b want 1000", op, off, {mem_re, mem_we, done, req_ready}); end
      req_valid = 1'b0; req_data = 32'h0;
      @(negedge clk);
      n_cmp++; if ({mem_re, mem_we, done} !== 3'b000) begin n_fail++; $display("FAIL sub_wait op%0d off%0d: got %b want 000", op, off, {mem_re, mem_we, done}); end
      @(negedge clk);
      n_cmp++; if ({mem_we, done, err, mem_re} !== 4'b1100) begin n_fail++; $display("FAIL sub_write op%0d off%0d: got %b want 1100", op, off, {mem_we, done, err, mem_re}); end
      n_cmp++; if (mem_wdata !== exp) begin n_fail++; $display("FAIL sub_wdata op%0d off%0d: got %h want %h", op, off, mem_wdata, exp); end
      n_cmp++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL sub_addr op%0d off%0d: got %h want %h", op, off, mem_addr, exp_addr); end
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_we, done} !== 3'b100) begin n_fail++; $display("FAIL sub_after op%0d off%0d: got %b want 100", op, off, {req_ready, mem_we, done}); end
   endtask

   task automatic test_err(input logic [1:0] op, input logic [31:0] addr);
      int we0;
      int re0;
      we0 = we_cnt; re0 = re_cnt;
      @(negedge clk); req_valid = 1'b1; req_op = op; req_addr = addr; req_data = 32'hCAFEBBCC;
      @(negedge clk);
      n_cmp++; if ({done, err, mem_we, mem_re} !== 4'b1100) begin n_fail++; $display("FAIL err_pulse op%0d addr %h: got %b want 1100", op, addr, {done, err, mem_we, mem_re}); end
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({req_ready, done, err} !== 3'b100) begin n_fail++; $display("FAIL err_after op%0d: got %b want 100", op, {req_ready, done, err}); end
      n_cmp++; if ((we_cnt !== we0) || (re_cnt !== re0)) begin n_fail++; $display("FAIL err_no_access op%0d: got we %0d re %0d want %0d %0d", op, we_cnt, re_cnt, we0, re0); end
   endtask

   task automatic test_reset_mid_wait();
      int we0;
      @(negedge clk); req_valid = 1'b1; req_op = 2'b10; req_addr = 32'h404; req_data = 32'hEE;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      we0 = we_cnt;
      rst = 1'b1;
      #1;
      n_cmp++; if ({req_ready, mem_re, mem_we, done, err} !== 5'b10000) begin n_fail++; $display("FAIL rstw_outputs: got %b want 10000", {req_ready, mem_re, mem_we, done, err}); end
      n_cmp++; if ((mem_addr !== 30'h0) || (mem_wdata !== 32'h0)) begin n_fail++; $display("FAIL rstw_busses: got %h %h want 0 0", mem_addr, mem_wdata); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_we, done} !== 3'b100) begin n_fail++; $display("FAIL rstw_after: got %b want 100", {req_ready, mem_we, done}); end
      n_cmp++; if (we_cnt !== we0) begin n_fail++; $display("FAIL rstw_no_write: got %0d writes want %0d", we_cnt, we0); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); req_valid = 1'b1; req_op = 2'b10; req_addr = 32'h501; req_data = 32'hAA;
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_re} !== 2'b01) begin n_fail++; $display("FAIL b2b_read: got %b want 01", {req_ready, mem_re}); end
      req_op = 2'b00; req_addr = 32'h600; req_data = 32'h0BADF00D;
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_we} !== 2'b00) begin n_fail++; $display("FAIL b2b_wait: got %b want 00", {req_ready, mem_we}); end
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_we, mem_wdata} !== {2'b01, 32'h11AA3344}) begin n_fail++; $display("FAIL b2b_sb_write: got %b %h want 01 11aa3344", {req_ready, mem_we}, mem_wdata); end
      n_cmp++; if (mem_addr !== 30'h140) begin n_fail++; $display("FAIL b2b_sb_addr: got %h want 140", mem_addr); end
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_we, done, mem_re} !== 4'b1000) begin n_fail++; $display("FAIL b2b_idle: got %b want 1000", {req_ready, mem_we, done, mem_re}); end
      @(negedge clk);
      n_cmp++; if ({mem_we, done, mem_re, req_ready} !== 4'b1100) begin n_fail++; $display("FAIL b2b_sw_write: got %b want 1100", {mem_we, done, mem_re, req_ready}); end
      n_cmp++; if ((mem_wdata !== 32'h0BADF00D) || (mem_addr !== 30'h180)) begin n_fail++; $display("FAIL b2b_sw_data: got %h @%h want 0badf00d @180", mem_wdata, mem_addr); end
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({req_ready, mem_we, done} !== 3'b100) begin n_fail++; $display("FAIL b2b_end: got %b want 100", {req_ready, mem_we, done}); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 32'h0; req_data = 32'h0;
      #1;
      test_reset();
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_sw();
      test_sub(2'b10, 2'b00, 32'hFFFFFFAA, 32'hAA223344, 30'h80);
      test_sub(2'b10, 2'b01, 32'hFFFFFFAA, 32'h11AA3344, 30'h80);
      test_sub(2'b10, 2'b10, 32'hFFFFFFAA, 32'h1122AA44, 30'h80);
      test_sub(2'b10, 2'b11, 32'hFFFFFFAA, 32'h112233AA, 30'h80);
      test_sub(2'b01, 2'b00, 32'h7777BBCC, 32'hBBCC3344, 30'hC0);
      test_sub(2'b01, 2'b10, 32'h7777BBCC, 32'h1122BBCC, 30'hC0);
      test_err(2'b01, 32'h301);
      test_err(2'b00, 32'h102);
      test_err(2'b11, 32'h100);
      test_reset_mid_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
